hack_ctrl: RTL and testbench
============================

Name: hack_ctrl

Overview:
- Multi-cycle Hack control unit: the producer side of the ALU control interface.
- Fetches 16-bit Hack instructions and decodes them into the six ALU control bits and operands. Drives an external ALU instance and consumes its out/zr/ng results.
- Owns the A, D and PC registers; performs data-memory read/write via req/ack handshakes.
- Sits between instruction ROM, data RAM and the ALU; together these form the CPU.

Parameters:
- PC_W, 15, width of pc and memory addresses
- RESET_PC, 0, pc value after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_data  in  16  instruction word, valid when imem_ack
- imem_ack  in  1  fetch complete, single-cycle pulse
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  PC_W  data address
- dmem_wdata  out  16  write data
- dmem_rdata  in  16  read data, valid when dmem_ack
- dmem_ack  in  1  data access complete, single-cycle pulse
- alu_x, alu_y  out  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1  ALU controls
- alu_out  in  16  ALU result
- alu_zr, alu_ng  in  1  ALU flags
- pc  out  PC_W  current program counter
- a_reg, d_reg  out  16  architectural registers (debug/verification)

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = FETCH, pc = RESET_PC, a_reg = 0, d_reg = 0, instruction latch = 0, M latch = 0.
  - imem_req, dmem_req, dmem_we = 0; dmem_addr = 0, dmem_wdata = 0.
  - Reset asserted mid-operation aborts the access. req drops asynchronously; the pending ack is ignored.
  - After release, imem_req rises in the first cycle.
- Handshake (both ports):
  - req is high for every cycle spent in the requesting state; addr/we/wdata are stable while req is high.
  - Transfer completes on the edge where req and ack are both 1. Zero-wait ack in the same cycle as req is legal.
  - req is low in the cycle after completion. ack while req is low is ignored.
- Decode:
  - instr[15]=0 → A-instruction.
  - instr[15]=1 → C-instruction; bits 14:13 are ignored.
  - C fields: a = instr[12]; zx, nx, zy, ny, f, no = instr[11:6]; dA, dD, dM = instr[5:3]; jlt, jeq, jgt = instr[2:0].
- FSM:
  - FETCH: imem_req = 1, imem_addr = pc. On ack, latch imem_data. If C and a = 1 → MREAD, else → EXEC.
  - MREAD: dmem_req = 1, we = 0, addr = a_reg[PC_W-1:0]. On ack, latch M → EXEC.
  - EXEC (exactly 1 cycle):
    - A-instruction: a_reg ← {1'b0, instr[14:0]}; pc ← pc + 1; → FETCH.
    - C-instruction:
      - ALU inputs: alu_x = d_reg; alu_y = a ? M latch : a_reg; controls come from the instruction latch.
      - jump = (jlt & ng) | (jeq & zr) | (jgt & ~ng & ~zr).
      - pc ← jump ? old a_reg[PC_W-1:0] : pc + 1.
      - If dA: a_reg ← alu_out. If dD: d_reg ← alu_out.
      - If dM: register dmem_addr ← old a_reg, dmem_wdata ← alu_out; → MWRITE. Else → FETCH.
  - MWRITE: dmem_req = 1, we = 1, using the registered addr/data. On ack → FETCH.
- Hazard rule: the jump target and the M address always use a_reg as it was before this instruction's A write (Hack semantics; "AM=..." writes the old address).
- Outside EXEC: ALU controls and operands are don't-care but must be driven (no X). Drive them from the latch.
- Arithmetic:
  - pc increment wraps modulo 2^PC_W; 0x7FFF + 1 → 0.
  - All data paths are 16-bit, no extension.
- Latency with zero-wait memory:
  - A-instruction or C-instruction without M: 2 cycles.
  - +1 cycle if a = 1; +1 cycle if dM.

Decomposition:
- Package hack_pkg holds:
  - state enum {FETCH, MREAD, EXEC, MWRITE};
  - instruction field bit positions (A_BIT = 12, COMP_MSB = 11, DEST_A = 5, DEST_D = 4, DEST_M = 3, J_LT = 2, J_EQ = 1, J_GT = 0);
  - width constants.
- One natural sub-module, hack_jump_unit: combinational jump decision from j bits, zr and ng.
- The ALU is instantiated outside, beside hack_ctrl. The bench instantiates it alongside the DUT.

Test Plan:
- Reset, then feed 0x0005 with immediate ack → a_reg = 5, pc = 1 after 2 cycles; no dmem_req.
- @7 then 0xEC10 (D=A) → d_reg = 7, pc = 2.
- With D = 7, @100 then 0xE7C8 (M=D+1) → dmem write with addr 100, wdata 8, we = 1. Hold ack off 3 cycles: req/addr/data stable throughout, then FETCH.
- With D = 7, @20 then 0xE301 (D;JGT) → pc = 20. Repeat with D = 0 → pc = previous + 1. 0xE307 (JMP) with A = 0x7FFF → pc = 0x7FFF, then pc increments wrap to 0.
- With RAM[100] = 0x1234, A = 100, feed 0xFC10 (D=M) → MREAD with addr 100, then d_reg = 0x1234; total 3 cycles with zero-wait memory.
- Assert rst_n mid-MWRITE while ack is held low → dmem_req drops immediately. After release: pc = RESET_PC, a_reg = d_reg = 0, FETCH restarts; a late ack is ignored.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack control unit: FSM states, instruction
// field positions and the decoded C-instruction control word.
package hack_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned COMP_W = 6;
    localparam int unsigned JMP_W  = 3;

    localparam int unsigned C_BIT    = 15;
    localparam int unsigned A_BIT    = 12;
    localparam int unsigned COMP_MSB = 11;
    localparam int unsigned DEST_A   = 5;
    localparam int unsigned DEST_D   = 4;
    localparam int unsigned DEST_M   = 3;
    localparam int unsigned J_LT     = 2;
    localparam int unsigned J_EQ     = 1;
    localparam int unsigned J_GT     = 0;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        MREAD  = 2'd1,
        EXEC   = 2'd2,
        MWRITE = 2'd3
    } state_t;

    // Decoded view of the instruction latch
    typedef struct packed {
        logic              is_c;
        logic              a;
        logic [COMP_W-1:0] comp;
        logic              dest_a;
        logic              dest_d;
        logic              dest_m;
        logic [JMP_W-1:0]  jmp;
    } ctl_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational jump decision from the j bits and the ALU zr/ng flags.
module hack_jump_unit
    import hack_pkg::*;
(
    input  logic [JMP_W-1:0] jmp,
    input  logic             zr,
    input  logic             ng,
    output logic             take_c
);

    assign take_c = (jmp[J_LT] & ng)
                  | (jmp[J_EQ] & zr)
                  | (jmp[J_GT] & ~ng & ~zr);

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack control unit: fetches and decodes instructions, drives an
// external ALU, and owns the A, D and PC registers plus the data-memory port.
module hack_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned PC_W     = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] instr_q, instr_nxt;
    logic [DATA_W-1:0] a_nxt, d_nxt, y_nxt, wdata_nxt;
    logic [PC_W-1:0]   pc_nxt, daddr_nxt, pc_inc;
    ctl_t              cf;
    logic              take_c;

    assign cf = '{
        is_c:   instr_q[C_BIT],
        a:      instr_q[A_BIT],
        comp:   instr_q[COMP_MSB -: COMP_W],
        dest_a: instr_q[DEST_A],
        dest_d: instr_q[DEST_D],
        dest_m: instr_q[DEST_M],
        jmp:    instr_q[J_LT:J_GT]
    };

    // ALU controls always come from the latch so they are never X
    assign alu_x     = d_reg;
    assign alu_zx    = cf.comp[5];
    assign alu_nx    = cf.comp[4];
    assign alu_zy    = cf.comp[3];
    assign alu_ny    = cf.comp[2];
    assign alu_f     = cf.comp[1];
    assign alu_no    = cf.comp[0];
    assign imem_addr = pc;
    assign pc_inc    = pc + PC_W'(1);

    hack_jump_unit u_jump (
        .jmp    (cf.jmp),
        .zr     (alu_zr),
        .ng     (alu_ng),
        .take_c (take_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    // Next-state and next-register values; jump target and M address use the
    // pre-instruction a_reg so "AM=..." writes the old address.
    always_comb begin
        state_nxt = state;
        instr_nxt = instr_q;
        a_nxt     = a_reg;
        d_nxt     = d_reg;
        pc_nxt    = pc;
        y_nxt     = alu_y;
        daddr_nxt = dmem_addr;
        wdata_nxt = dmem_wdata;
        case (state)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    instr_nxt = imem_data;
                    y_nxt     = a_reg;
                    if (imem_data[C_BIT] && imem_data[A_BIT]) begin
                        state_nxt = MREAD;
                        daddr_nxt = a_reg[PC_W-1:0];
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            MREAD: begin
                if (dmem_req && dmem_ack) begin
                    y_nxt     = dmem_rdata;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = FETCH;
                if (!cf.is_c) begin
                    a_nxt  = {1'b0, instr_q[C_BIT-1:0]};
                    pc_nxt = pc_inc;
                end else begin
                    pc_nxt = take_c ? a_reg[PC_W-1:0] : pc_inc;
                    if (cf.dest_a) a_nxt = alu_out;
                    if (cf.dest_d) d_nxt = alu_out;
                    if (cf.dest_m) begin
                        daddr_nxt = a_reg[PC_W-1:0];
                        wdata_nxt = alu_out;
                        state_nxt = MWRITE;
                    end
                end
            end
            MWRITE: begin
                if (dmem_req && dmem_ack) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Request strobes are registered from the next state, so they drop the
    // cycle after a completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= PC_W'(RESET_PC);
            a_reg      <= '0;
            d_reg      <= '0;
            instr_q    <= '0;
            alu_y      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            pc         <= pc_nxt;
            a_reg      <= a_nxt;
            d_reg      <= d_nxt;
            instr_q    <= instr_nxt;
            alu_y      <= y_nxt;
            imem_req   <= (state_nxt == FETCH);
            dmem_req   <= (state_nxt == MREAD) || (state_nxt == MWRITE);
            dmem_we    <= (state_nxt == MWRITE);
            dmem_addr  <= daddr_nxt;
            dmem_wdata <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_hack_ctrl.sv
// Directed bench for hack_ctrl with a behavioural Hack ALU beside the DUT.
module tb_hack_ctrl;

    localparam int unsigned PC_W = 15;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;

    int passed = 0;
    int total  = 0;

    hack_ctrl #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    // Reference Hack ALU
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = alu_zx ? 16'h0000 : alu_x;
        if (alu_nx) ax = ~ax;
        ay = alu_zy ? 16'h0000 : alu_y;
        if (alu_ny) ay = ~ay;
        ao = alu_f ? 16'(ax + ay) : (ax & ay);
        if (alu_no) ao = ~ao;
    end
    assign alu_out = ao;
    assign alu_zr  = (ao == 16'h0000);
    assign alu_ng  = ao[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rd;
        logic [15:0] a;
        logic [15:0] d;
        logic [14:0] pc;
        int          cyc;
        logic        rdn;
        logic        wr;
        logic [14:0] addr;
        logic [15:0] wdata;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] rd,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic [14:0] p, input int cyc, input logic rdn,
                                input logic wr, input logic [14:0] addr, input logic [15:0] wdata);
        vec_t v;
        v.instr = instr; v.rd = rd; v.a = a; v.d = d; v.pc = p; v.cyc = cyc;
        v.rdn = rdn; v.wr = wr; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic wait_imem(input string nm);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " imem_req wait"}, 32'(imem_req), 32'd1);
    endtask

    // Fetch one instruction with zero-wait memory and service any data access
    task automatic run(input vec_t v, input int idx);
        int          cyc;
        logic        wr_seen, rd_seen;
        logic [14:0] wa, ra;
        logic [15:0] wd;
        string       nm;
        nm = $sformatf("v%0d", idx);
        wr_seen = 1'b0; rd_seen = 1'b0; wa = '0; ra = '0; wd = '0;
        wait_imem(nm);
        imem_data = v.instr;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        cyc = 1;
        while (!imem_req && cyc < 20) begin
            if (dmem_req) begin
                if (dmem_we) begin
                    wr_seen = 1'b1; wa = dmem_addr; wd = dmem_wdata;
                end else begin
                    rd_seen = 1'b1; ra = dmem_addr; dmem_rdata = v.rd;
                end
                dmem_ack = 1'b1;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            cyc++;
        end
        chk({nm, " cycles"},    32'(cyc),       32'(v.cyc));
        chk({nm, " a_reg"},     32'(a_reg),     32'(v.a));
        chk({nm, " d_reg"},     32'(d_reg),     32'(v.d));
        chk({nm, " pc"},        32'(pc),        32'(v.pc));
        chk({nm, " imem_addr"}, 32'(imem_addr), 32'(v.pc));
        chk({nm, " read seen"}, 32'(rd_seen),   32'(v.rdn));
        chk({nm, " write seen"},32'(wr_seen),   32'(v.wr));
        if (v.rdn) chk({nm, " read addr"},  32'(ra), 32'(v.addr));
        if (v.wr) begin
            chk({nm, " write addr"}, 32'(wa), 32'(v.addr));
            chk({nm, " write data"}, 32'(wd), 32'(v.wdata));
        end
    endtask

    // Fetch an instruction without waiting for completion
    task automatic fetch_only(input logic [15:0] w, input string nm);
        wait_imem(nm);
        imem_data = w;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic wait_dmem(input string nm);
        int n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " dmem_req wait"}, 32'(dmem_req), 32'd1);
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_data = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        vt.push_back(mk(16'h0005, 16'h0,    16'd5,    16'd0,    15'd1,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0007, 16'h0,    16'd7,    16'd0,    15'd2,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hEC10, 16'h0,    16'd7,    16'd7,    15'd3,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0064, 16'h0,    16'd100,  16'd7,    15'd4,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE7C8, 16'h0,    16'd100,  16'd7,    15'd5,    3, 0, 1, 15'd100, 16'd8));
        vt.push_back(mk(16'h0014, 16'h0,    16'd20,   16'd7,    15'd6,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE301, 16'h0,    16'd20,   16'd7,    15'd20,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0000, 16'h0,    16'd0,    16'd7,    15'd21,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hEC10, 16'h0,    16'd0,    16'd0,    15'd22,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0014, 16'h0,    16'd20,   16'd0,    15'd23,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE301, 16'h0,    16'd20,   16'd0,    15'd24,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0064, 16'h0,    16'd100,  16'd0,    15'd25,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hFC10, 16'h1234, 16'd100,  16'h1234, 15'd26,   3, 1, 0, 15'd100, 16'h0));
        vt.push_back(mk(16'hFDE8, 16'h0010, 16'h0011, 16'h1234, 15'd27,   4, 1, 1, 15'd100, 16'h0011));
        vt.push_back(mk(16'hE327, 16'h0,    16'h1234, 16'h1234, 15'h0011, 2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h7FFF, 16'h0,    16'h7FFF, 16'h1234, 15'h0012, 2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE307, 16'h0,    16'h7FFF, 16'h1234, 15'h7FFF, 2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0000, 16'h0,    16'h0000, 16'h1234, 15'd0,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE304, 16'h0,    16'h0000, 16'h1234, 15'd1,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hEE90, 16'h0,    16'h0000, 16'hFFFF, 15'd2,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'h0009, 16'h0,    16'd9,    16'hFFFF, 15'd3,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE304, 16'h0,    16'd9,    16'hFFFF, 15'd9,    2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hEA90, 16'h0,    16'd9,    16'd0,    15'd10,   2, 0, 0, 15'd0,   16'h0));
        vt.push_back(mk(16'hE302, 16'h0,    16'd9,    16'd0,    15'd9,    2, 0, 0, 15'd0,   16'h0));

        // Reset state
        #12;
        chk("rst imem_req",   32'(imem_req),   32'd0);
        chk("rst dmem_req",   32'(dmem_req),   32'd0);
        chk("rst dmem_we",    32'(dmem_we),    32'd0);
        chk("rst dmem_addr",  32'(dmem_addr),  32'd0);
        chk("rst dmem_wdata", 32'(dmem_wdata), 32'd0);
        chk("rst pc",         32'(pc),         32'd0);
        chk("rst a_reg",      32'(a_reg),      32'd0);
        chk("rst d_reg",      32'(d_reg),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) run(vt[i], i);

        // Data write held off three cycles: request must stay stable
        run(mk(16'h0064, 16'h0, 16'd100, 16'd0, 15'd10, 2, 0, 0, 15'd0, 16'h0), 100);
        fetch_only(16'hE7C8, "hold");
        wait_dmem("hold");
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d req", k),   32'(dmem_req),   32'd1);
            chk($sformatf("hold%0d we", k),    32'(dmem_we),    32'd1);
            chk($sformatf("hold%0d addr", k),  32'(dmem_addr),  32'd100);
            chk($sformatf("hold%0d wdata", k), 32'(dmem_wdata), 32'd1);
            chk($sformatf("hold%0d imem", k),  32'(imem_req),   32'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("hold done dmem_req", 32'(dmem_req), 32'd0);
        chk("hold done imem_req", 32'(imem_req), 32'd1);
        chk("hold done pc",       32'(pc),       32'd11);

        // Reset in the middle of a stalled write; late ack must be ignored
        run(mk(16'h0064, 16'h0, 16'd100, 16'd0, 15'd12, 2, 0, 0, 15'd0, 16'h0), 101);
        fetch_only(16'hE7C8, "abort");
        wait_dmem("abort");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort dmem_req", 32'(dmem_req), 32'd0);
        chk("abort dmem_we",  32'(dmem_we),  32'd0);
        chk("abort pc",       32'(pc),       32'd0);
        chk("abort a_reg",    32'(a_reg),    32'd0);
        chk("abort d_reg",    32'(d_reg),    32'd0);
        dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("abort late ack dmem_req", 32'(dmem_req), 32'd0);
        wait_imem("abort restart");
        chk("abort restart pc", 32'(pc), 32'd0);
        run(mk(16'h0003, 16'h0, 16'd3, 16'd0, 15'd1, 2, 0, 0, 15'd0, 16'h0), 102);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
